dispatch_ctrl: RTL and testbench

//  In-order dispatch/rename sequencer between the instruction queue and the Tomasulo back end.

---
 rtl/dispatch_ctrl_if.sv | 85 ++++++++
 rtl/dispatch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dispatch_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_ctrl_if
//  Purpose  : Bundles the IQ pop, ROB allocate, regFile read/rename, CDB snoop
//             and RS/LSB launch signals of the dispatch sequencer.
//             master = dispatch_ctrl side, slave = surrounding back end.
//  Revision : 1.0  initial release
// ============================================================================
interface dispatch_ctrl_if #(
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
);
    logic              rdy;
    // instruction queue head
    logic              iq_valid;
    logic              iq_ready;
    logic [OP_W-1:0]   iq_op;
    logic [31:0]       iq_imm;
    logic [31:0]       iq_pc;
    logic [4:0]        iq_rd;
    logic [4:0]        iq_rs1;
    logic [4:0]        iq_rs2;
    logic              iq_use_rs1;
    logic              iq_use_rs2;
    logic              iq_has_rd;
    logic              iq_is_mem;
    // reorder buffer
    logic              rob_full;
    logic [TAG_W-1:0]  rob_tail_tag;
    logic              rob_alloc;
    // station back-pressure
    logic              rs_full;
    logic              lsb_full;
    // register file read / rename
    logic [4:0]        reg1;
    logic [4:0]        reg2;
    logic [31:0]       val1;
    logic [31:0]       val2;
    logic [TAG_W:0]    rob_tag1;
    logic [TAG_W:0]    rob_tag2;
    logic              issue_sig;
    logic [4:0]        issue_rd;
    logic [TAG_W-1:0]  issue_rob_tag;
    // common data bus and flush
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_val;
    logic              clear;
    // launch packet
    logic              out_rs_valid;
    logic              out_lsb_valid;
    logic [OP_W-1:0]   out_op;
    logic [31:0]       out_pc;
    logic [31:0]       out_imm;
    logic [4:0]        out_rd;
    logic [TAG_W-1:0]  out_rob_tag;
    logic [31:0]       out_v1;
    logic [31:0]       out_v2;
    logic [TAG_W:0]    out_q1;
    logic [TAG_W:0]    out_q2;
    logic [31:0]       stall_cnt;

    modport master (
        input  rdy, iq_valid, iq_op, iq_imm, iq_pc, iq_rd, iq_rs1, iq_rs2,
               iq_use_rs1, iq_use_rs2, iq_has_rd, iq_is_mem,
               rob_full, rob_tail_tag, rs_full, lsb_full,
               val1, val2, rob_tag1, rob_tag2,
               cdb_valid, cdb_tag, cdb_val, clear,
        output iq_ready, rob_alloc, reg1, reg2, issue_sig, issue_rd, issue_rob_tag,
               out_rs_valid, out_lsb_valid, out_op, out_pc, out_imm, out_rd,
               out_rob_tag, out_v1, out_v2, out_q1, out_q2, stall_cnt
    );

    modport slave (
        output rdy, iq_valid, iq_op, iq_imm, iq_pc, iq_rd, iq_rs1, iq_rs2,
               iq_use_rs1, iq_use_rs2, iq_has_rd, iq_is_mem,
               rob_full, rob_tail_tag, rs_full, lsb_full,
               val1, val2, rob_tag1, rob_tag2,
               cdb_valid, cdb_tag, cdb_val, clear,
        input  iq_ready, rob_alloc, reg1, reg2, issue_sig, issue_rd, issue_rob_tag,
               out_rs_valid, out_lsb_valid, out_op, out_pc, out_imm, out_rd,
               out_rob_tag, out_v1, out_v2, out_q1, out_q2, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_ctrl
//  Purpose  : In-order dispatch/rename sequencer. Pops one IQ entry per cycle,
//             allocates its ROB tag, resolves both sources against regFile and
//             the CDB, renames the destination and launches a registered packet
//             to the RS or LSB. Owns stall accounting and flush sequencing.
//  Revision : 1.0  initial release
// ============================================================================
module dispatch_ctrl #(
    parameter int TAG_W     = 4,
    parameter int OP_W      = 6,
    parameter int FLUSH_GAP = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dispatch_ctrl_if.master bus
);
    localparam int              CNT_W    = (FLUSH_GAP < 2) ? 1 : $clog2(FLUSH_GAP + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(FLUSH_GAP);
    localparam logic [CNT_W-1:0] GAP_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [31:0]        stall_q;

    logic               rs_valid_q, lsb_valid_q;
    logic [OP_W-1:0]    op_q;
    logic [31:0]        pc_q, imm_q, v1_q, v2_q;
    logic [4:0]         rd_q;
    logic [TAG_W-1:0]   tag_q;
    logic [TAG_W:0]     q1_q, q2_q;

    logic               go;
    logic [4:0]         dest;
    logic [32+TAG_W:0]  src1, src2;

    // Resolve one source to {value, {pending, tag}}. A tag matching the CDB in
    // this very cycle is captured here because regFile only sees it next edge.
    function automatic logic [32+TAG_W:0] resolve(
        input logic             use_s,
        input logic [4:0]       idx,
        input logic [31:0]      val,
        input logic [TAG_W:0]   btag,
        input logic             cv,
        input logic [TAG_W-1:0] ct,
        input logic [31:0]      cval
    );
        logic [31:0]    v;
        logic [TAG_W:0] q;
        v = '0;
        q = '0;
        if (!use_s) begin
            v = '0;
        end else if (idx == 5'd0) begin
            v = val;
        end else if (btag[TAG_W] && cv && (ct == btag[TAG_W-1:0])) begin
            v = cval;
        end else if (btag[TAG_W]) begin
            q = btag;
        end else begin
            v = val;
        end
        return {v, q};
    endfunction

    // Dispatch fires only in RUN with the head valid and every target free.
    always_comb begin
        go = !rst && bus.rdy && (state_q == ST_RUN) && !bus.clear && bus.iq_valid &&
             !bus.rob_full && (bus.iq_is_mem ? !bus.lsb_full : !bus.rs_full);
    end

    // Destination index and operand resolution for the current head.
    always_comb begin
        dest = bus.iq_has_rd ? bus.iq_rd : 5'd0;
        src1 = resolve(bus.iq_use_rs1, bus.iq_rs1, bus.val1, bus.rob_tag1,
                       bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
        src2 = resolve(bus.iq_use_rs2, bus.iq_rs2, bus.val2, bus.rob_tag2,
                       bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
    end

    assign bus.iq_ready      = go;
    assign bus.rob_alloc     = go;
    assign bus.issue_sig     = go && bus.iq_has_rd && (bus.iq_rd != 5'd0);
    assign bus.reg1          = rst ? 5'd0 : bus.iq_rs1;
    assign bus.reg2          = rst ? 5'd0 : bus.iq_rs2;
    assign bus.issue_rd      = rst ? 5'd0 : dest;
    assign bus.issue_rob_tag = rst ? '0 : bus.rob_tail_tag;

    // Flush sequencing: clear (re)loads the gap counter, RUN resumes when it expires.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        if (bus.rdy) begin
            if (bus.clear) begin
                state_d = ST_FLUSH;
                gap_d   = GAP_LOAD;
            end else if (state_q == ST_FLUSH) begin
                if (gap_q <= GAP_ONE) begin
                    state_d = ST_RUN;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Saturating count of RUN cycles where a valid head could not be popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (bus.rdy && (state_q == ST_RUN) && bus.iq_valid && !go &&
                     (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    // Launch packet: captured on go, valids pulse for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_valid_q  <= 1'b0;
            lsb_valid_q <= 1'b0;
            op_q        <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            tag_q       <= '0;
            v1_q        <= '0;
            v2_q        <= '0;
            q1_q        <= '0;
            q2_q        <= '0;
        end else begin
            rs_valid_q  <= go && !bus.iq_is_mem;
            lsb_valid_q <= go && bus.iq_is_mem;
            if (go) begin
                op_q  <= bus.iq_op;
                pc_q  <= bus.iq_pc;
                imm_q <= bus.iq_imm;
                rd_q  <= dest;
                tag_q <= bus.rob_tail_tag;
                v1_q  <= src1[32+TAG_W:TAG_W+1];
                q1_q  <= src1[TAG_W:0];
                v2_q  <= src2[32+TAG_W:TAG_W+1];
                q2_q  <= src2[TAG_W:0];
            end
        end
    end

    assign bus.out_rs_valid  = rs_valid_q;
    assign bus.out_lsb_valid = lsb_valid_q;
    assign bus.out_op        = op_q;
    assign bus.out_pc        = pc_q;
    assign bus.out_imm       = imm_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_rob_tag   = tag_q;
    assign bus.out_v1        = v1_q;
    assign bus.out_v2        = v2_q;
    assign bus.out_q1        = q1_q;
    assign bus.out_q2        = q2_q;
    assign bus.stall_cnt     = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dispatch_ctrl
//  Purpose  : Self-checking bench for dispatch_ctrl. Plays the regFile, ROB
//             and stations, keeps an architectural rename model, and compares
//             every cycle plus directed literal scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dispatch_ctrl;
    localparam int TAG_W     = 4;
    localparam int OP_W      = 6;
    localparam int FLUSH_GAP = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dispatch_ctrl_if #(.TAG_W(TAG_W), .OP_W(OP_W)) bus ();

    dispatch_ctrl #(.TAG_W(TAG_W), .OP_W(OP_W), .FLUSH_GAP(FLUSH_GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // architectural regFile / ROB model
    logic [31:0]      rf_val  [32];
    logic             rf_busy [32];
    logic [TAG_W-1:0] rf_tag  [32];
    logic [TAG_W-1:0] tail;
    int               gap;
    logic [31:0]      m_stall;
    logic             m_known;
    // expected launch packet
    logic             m_rs_v, m_lsb_v;
    logic [OP_W-1:0]  m_op;
    logic [31:0]      m_pc, m_imm, m_v1, m_v2;
    logic [4:0]       m_rd;
    logic [TAG_W-1:0] m_tag;
    logic [TAG_W:0]   m_q1, m_q2;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.rdy = 1'b1;       bus.iq_valid = 1'b0;  bus.clear = 1'b0;
        bus.rob_full = 1'b0;  bus.rs_full = 1'b0;   bus.lsb_full = 1'b0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0;     bus.cdb_val = '0;
        bus.iq_op = '0;       bus.iq_imm = '0;      bus.iq_pc = '0;
        bus.iq_rd = '0;       bus.iq_rs1 = '0;      bus.iq_rs2 = '0;
        bus.iq_use_rs1 = 1'b0; bus.iq_use_rs2 = 1'b0;
        bus.iq_has_rd = 1'b0;  bus.iq_is_mem = 1'b0;
    endtask

    task automatic set_inst(input logic [OP_W-1:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2, input logic hr, input logic mem);
        bus.iq_valid = 1'b1; bus.iq_op = op; bus.iq_rd = rd;
        bus.iq_rs1 = rs1; bus.iq_rs2 = rs2; bus.iq_use_rs1 = u1; bus.iq_use_rs2 = u2;
        bus.iq_has_rd = hr; bus.iq_is_mem = mem;
        bus.iq_pc = $urandom; bus.iq_imm = $urandom;
    endtask

    // regFile read ports and ROB tail follow the bench's own rename state
    task automatic drive_rf();
        bus.val1 = rf_val[bus.iq_rs1];
        bus.val2 = rf_val[bus.iq_rs2];
        bus.rob_tag1 = {rf_busy[bus.iq_rs1], rf_tag[bus.iq_rs1]};
        bus.rob_tag2 = {rf_busy[bus.iq_rs2], rf_tag[bus.iq_rs2]};
        bus.rob_tail_tag = tail;
    endtask

    task automatic expect_src(input logic use_s, input logic [4:0] rs,
                              output logic [31:0] v, output logic [TAG_W:0] q);
        v = '0;
        q = '0;
        if (use_s) begin
            if (rs == 5'd0)                                          v = rf_val[0];
            else if (!rf_busy[rs])                                   v = rf_val[rs];
            else if (bus.cdb_valid && bus.cdb_tag == rf_tag[rs])     v = bus.cdb_val;
            else                                                     q = {1'b1, rf_tag[rs]};
        end
    endtask

    // One clock: compare registered and combinational outputs, advance model.
    task automatic tick();
        logic           go, iss;
        logic [31:0]    v1, v2;
        logic [TAG_W:0] q1, q2;
        drive_rf();
        #1;
        if (m_known) begin
            check("out_rs_valid",  bus.out_rs_valid,  m_rs_v);
            check("out_lsb_valid", bus.out_lsb_valid, m_lsb_v);
            check("out_op",        bus.out_op,        m_op);
            check("out_pc",        bus.out_pc,        m_pc);
            check("out_imm",       bus.out_imm,       m_imm);
            check("out_rd",        bus.out_rd,        m_rd);
            check("out_rob_tag",   bus.out_rob_tag,   m_tag);
            check("out_v1",        bus.out_v1,        m_v1);
            check("out_v2",        bus.out_v2,        m_v2);
            check("out_q1",        bus.out_q1,        m_q1);
            check("out_q2",        bus.out_q2,        m_q2);
            check("stall_cnt",     bus.stall_cnt,     m_stall);
        end
        go = !rst && bus.rdy && (gap == 0) && !bus.clear && bus.iq_valid && !bus.rob_full &&
             (bus.iq_is_mem ? !bus.lsb_full : !bus.rs_full);
        iss = go && bus.iq_has_rd && (bus.iq_rd != 5'd0);
        check("iq_ready",  bus.iq_ready,  go);
        check("rob_alloc", bus.rob_alloc, go);
        check("issue_sig", bus.issue_sig, iss);
        check("reg1", bus.reg1, rst ? 5'd0 : bus.iq_rs1);
        check("reg2", bus.reg2, rst ? 5'd0 : bus.iq_rs2);
        if (go) begin
            check("issue_rd",      bus.issue_rd,      bus.iq_has_rd ? bus.iq_rd : 5'd0);
            check("issue_rob_tag", bus.issue_rob_tag, tail);
        end
        if (rst) begin
            check("rst_issue_rd", bus.issue_rd, 0);
            check("rst_issue_tag", bus.issue_rob_tag, 0);
        end
        expect_src(bus.iq_use_rs1, bus.iq_rs1, v1, q1);
        expect_src(bus.iq_use_rs2, bus.iq_rs2, v2, q2);

        if (rst) begin
            m_rs_v = 0; m_lsb_v = 0; m_op = '0; m_pc = '0; m_imm = '0; m_rd = '0;
            m_tag = '0; m_v1 = '0; m_v2 = '0; m_q1 = '0; m_q2 = '0;
            m_stall = '0; gap = 0; m_known = 1'b1;
            for (int r = 0; r < 32; r++) rf_busy[r] = 1'b0;
        end else if (bus.rdy) begin
            if (gap == 0 && bus.iq_valid && !go && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (bus.clear) gap = FLUSH_GAP;
            else if (gap > 0) gap--;
            m_rs_v  = go && !bus.iq_is_mem;
            m_lsb_v = go && bus.iq_is_mem;
            if (go) begin
                m_op = bus.iq_op; m_pc = bus.iq_pc; m_imm = bus.iq_imm;
                m_rd = bus.iq_has_rd ? bus.iq_rd : 5'd0; m_tag = tail;
                m_v1 = v1; m_q1 = q1; m_v2 = v2; m_q2 = q2;
            end
            if (bus.clear) begin
                for (int r = 0; r < 32; r++) rf_busy[r] = 1'b0;
            end else begin
                if (bus.cdb_valid) begin
                    for (int r = 1; r < 32; r++) begin
                        if (rf_busy[r] && rf_tag[r] == bus.cdb_tag) begin
                            rf_val[r]  = bus.cdb_val;
                            rf_busy[r] = 1'b0;
                        end
                    end
                end
                if (iss) begin
                    rf_busy[bus.iq_rd] = 1'b1;
                    rf_tag[bus.iq_rd]  = tail;
                end
            end
            if (go) tail = tail + 1'b1;
        end else begin
            m_rs_v  = 1'b0;
            m_lsb_v = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int r;
        for (int i = 0; i < 32; i++) begin
            rf_val[i]  = (i == 0) ? 32'd0 : 32'd100 + i;
            rf_busy[i] = 1'b0;
            rf_tag[i]  = '0;
        end
        tail = '0; gap = 0; m_stall = '0; m_known = 1'b0;
        m_rs_v = 0; m_lsb_v = 0; m_op = '0; m_pc = '0; m_imm = '0; m_rd = '0;
        m_tag = '0; m_v1 = '0; m_v2 = '0; m_q1 = '0; m_q2 = '0;
        set_idle();
        drive_rf();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive_rf(); #1;
        check("reset_rs_valid", bus.out_rs_valid, 0);
        check("reset_stall",    bus.stall_cnt,    0);
        check("reset_q1",       bus.out_q1,       0);

        // add x5,x1,x2 with idle registers
        tail = 4'd3;
        set_inst(6'd1, 5'd5, 5'd1, 5'd2, 1, 1, 1, 0);
        drive_rf(); #1;
        check("t1_iq_ready",  bus.iq_ready,      1);
        check("t1_issue_sig", bus.issue_sig,     1);
        check("t1_issue_rd",  bus.issue_rd,      5);
        check("t1_issue_tag", bus.issue_rob_tag, 3);
        tick();
        // sub x6,x5,x5 right behind it
        set_inst(6'd2, 5'd6, 5'd5, 5'd5, 1, 1, 1, 0);
        drive_rf(); #1;
        check("t1_rs_valid", bus.out_rs_valid, 1);
        check("t1_q1",       bus.out_q1,       0);
        check("t1_q2",       bus.out_q2,       0);
        check("t1_v1",       bus.out_v1,       101);
        check("t1_v2",       bus.out_v2,       102);
        tick();
        // sub x7,x5,x5 while the CDB broadcasts tag 3 = 7
        set_inst(6'd3, 5'd7, 5'd5, 5'd5, 1, 1, 1, 0);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd3; bus.cdb_val = 32'd7;
        drive_rf(); #1;
        check("t2_q1",  bus.out_q1,      5'h13);
        check("t2_q2",  bus.out_q2,      5'h13);
        check("t2_tag", bus.out_rob_tag, 4);
        tick();
        set_idle();
        drive_rf(); #1;
        check("t2_cdb_v1", bus.out_v1, 7);
        check("t2_cdb_v2", bus.out_v2, 7);
        check("t2_cdb_q1", bus.out_q1, 0);
        tick();

        // ROB full for four cycles
        set_inst(6'd1, 5'd8, 5'd1, 5'd2, 1, 1, 1, 0);
        bus.rob_full = 1'b1;
        repeat (4) begin
            drive_rf(); #1;
            check("t3_no_pop",   bus.iq_ready,  0);
            check("t3_no_issue", bus.issue_sig, 0);
            tick();
        end
        bus.rob_full = 1'b0;
        drive_rf(); #1;
        check("t3_stall_cnt", bus.stall_cnt, 4);
        check("t3_resume",    bus.iq_ready,  1);
        tick();

        // load blocked by LSB only
        set_idle();
        set_inst(6'd4, 5'd9, 5'd1, 5'd0, 1, 0, 1, 1);
        bus.lsb_full = 1'b1;
        repeat (2) begin
            drive_rf(); #1;
            check("t4_stall", bus.iq_ready, 0);
            tick();
        end
        bus.lsb_full = 1'b0;
        drive_rf(); #1;
        check("t4_go", bus.iq_ready, 1);
        tick();
        set_idle();
        drive_rf(); #1;
        check("t4_lsb_valid", bus.out_lsb_valid, 1);
        check("t4_rs_valid",  bus.out_rs_valid,  0);
        check("t4_v1",        bus.out_v1,        101);
        tick();

        // clear right after a dispatch
        set_inst(6'd1, 5'd10, 5'd1, 5'd2, 1, 1, 1, 0);
        drive_rf(); #1;
        check("t5_go", bus.iq_ready, 1);
        tick();
        bus.clear = 1'b1;
        drive_rf(); #1;
        check("t5_clear_block", bus.iq_ready, 0);
        tick();
        bus.clear = 1'b0;
        drive_rf(); #1;
        check("t5_gap_block",    bus.iq_ready,     0);
        check("t5_valid_dropped", bus.out_rs_valid, 0);
        tick();
        drive_rf(); #1;
        check("t5_resume", bus.iq_ready, 1);
        tick();
        set_idle();
        tick();

        // x0 sources with a bogus busy tag, rd = x0
        rf_busy[0] = 1'b1; rf_tag[0] = 4'd9;
        set_inst(6'd5, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0);
        drive_rf(); #1;
        check("t6_iq_ready",  bus.iq_ready,  1);
        check("t6_issue_sig", bus.issue_sig, 0);
        tick();
        rf_busy[0] = 1'b0;
        set_idle();
        drive_rf(); #1;
        check("t6_q1", bus.out_q1, 0);
        check("t6_q2", bus.out_q2, 0);
        check("t6_v1", bus.out_v1, 0);
        check("t6_rd", bus.out_rd, 0);
        tick();
        // reset in the middle of traffic
        set_inst(6'd1, 5'd11, 5'd1, 5'd2, 1, 1, 1, 0);
        rst = 1'b1;
        drive_rf(); #1;
        check("t6_rst_ready", bus.iq_ready,  0);
        check("t6_rst_sig",   bus.issue_sig, 0);
        check("t6_rst_reg1",  bus.reg1,      0);
        tick();
        rst = 1'b0;
        set_idle();
        drive_rf(); #1;
        check("t6_rst_stall",    bus.stall_cnt,    0);
        check("t6_rst_rs_valid", bus.out_rs_valid, 0);
        check("t6_rst_pc",       bus.out_pc,       0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.rdy      = ($urandom_range(0, 9) != 0);
            bus.clear    = ($urandom_range(0, 39) == 0);
            bus.iq_valid = ($urandom_range(0, 3) != 0);
            bus.iq_op    = OP_W'($urandom);
            bus.iq_pc    = $urandom;
            bus.iq_imm   = $urandom;
            bus.iq_rd    = 5'($urandom_range(0, 7));
            bus.iq_rs1   = 5'($urandom_range(0, 7));
            bus.iq_rs2   = 5'($urandom_range(0, 7));
            bus.iq_use_rs1 = $urandom_range(0, 3) != 0;
            bus.iq_use_rs2 = $urandom_range(0, 1) != 0;
            bus.iq_has_rd  = $urandom_range(0, 3) != 0;
            bus.iq_is_mem  = $urandom_range(0, 2) == 0;
            bus.rob_full   = ($urandom_range(0, 5) == 0);
            bus.rs_full    = ($urandom_range(0, 4) == 0);
            bus.lsb_full   = ($urandom_range(0, 4) == 0);
            r = $urandom_range(1, 7);
            bus.cdb_valid = rf_busy[r] && ($urandom_range(0, 1) != 0);
            bus.cdb_tag   = rf_tag[r];
            bus.cdb_val   = $urandom;
            tick();
        end
        rst = 1'b0;
        set_idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
